fip_32_sqrt_iter: RTL and testbench
===================================

# fip_32_sqrt_iter

Iterative unsigned fixed-point square root. It takes a Q(32−FRA_BITS).FRA_BITS radicand and returns its root in the same format, one result bit per clock, behind a busy/valid handshake. It is the inverse of the squaring stage in vector normalisation: it consumes the sum of squares and feeds the divider stage. It is area-lean: one operation in flight at a time.

## Interface
- FRA_BITS, 16, number of fractional bits in radicand and root; must be even and no greater than 30.
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_en  input  1  start request; sampled only when not busy.
- i_rad  input  32  radicand, unsigned fixed-point.
- o_root  output  32  root, unsigned fixed-point; zero-extended above bit ITER.
- o_busy  output  1  high while an operation is iterating.
- o_valid  output  1  one-cycle pulse; o_root holds a new result.

## Operation
- Constant ITER = (32+FRA_BITS)/2, which is 24 at default.
- Internal operand is OP = {i_rad, FRA_BITS zeros}, 32+FRA_BITS bits wide, so o_root = floor(sqrt(OP)) as an integer.
- Method is restoring digit-by-digit.
  - Registers: OP shift register, remainder (ITER+2 bits), partial root (ITER bits), iteration counter.
  - Per iteration: rem' = {rem, OP[top two bits]}, OP <<= 2, trial = {root, 2'b01}.
  - If rem' ≥ trial: rem = rem' − trial and root = {root, 1}. Otherwise rem = rem' and root = {root, 0}.
- State machine (IDLE, CALC, DONE):
  - IDLE: i_en=1 loads OP, clears rem, root and counter, then goes to CALC.
  - CALC: one iteration per edge. On the ITER-th iteration edge it registers o_root, sets o_valid=1 and goes to DONE.
  - DONE: o_valid returns to 0 at the next edge. i_en=1 in DONE starts a new operation exactly as from IDLE; otherwise it goes to IDLE.
- i_en while in CALC is ignored. i_rad is not captured, and the running operation and its result are unaffected.
- o_root holds its last result until the next result is written. It does not change at operation start.
- Arithmetic is unsigned throughout. No negative inputs exist, and there is no overflow: the root always fits in ITER+1 bits, the extra bit being needed only by rounding.

## Timing
- Reset (i_rstn=0, asynchronous): state=IDLE, o_root=0, o_busy=0, o_valid=0, and all internal registers are cleared. Reset during CALC aborts the operation with no o_valid.
- Accept edge k: o_busy=1 from after edge k.
- Iterations run on edges k+1 … k+ITER.
- After edge k+ITER: o_valid=1, o_busy=0, and o_root is valid.
- Latency is ITER cycles, 24 at default. Back-to-back throughput is one result per ITER+1 cycles.
- o_busy is registered, equal to (state==CALC).

## Configuration
- FIP_SQRT_ROUND_EN:
  - Defined: round to nearest. The final edge writes root + (rem > root), with rem and root being the post-iteration values; ties cannot occur.
  - Undefined: truncation, o_root = final root.
- Latency and handshake are identical in both builds.

## Structure
- Shared package fip_pkg holds:
  - FIP_FRA_BITS (16), FIP_MIN and FIP_MAX.
  - The state enum type fip_sqrt_state_t {IDLE, CALC, DONE}.
- Sub-module fip_sqrt_step: combinational single iteration.
  - Inputs: rem, root, top two OP bits.
  - Outputs: next rem, next root.
  - Parameterised by ITER. It is instantiated once and reused every cycle.

## Test plan
- i_rad=0x00040000 (4.0), i_en one cycle: o_busy high for 24 cycles, then o_valid pulse with o_root=0x00020000 exactly 24 cycles after the accept edge.
- i_rad=0x00020000 (2.0): o_root=0x00016A09 without the macro, 0x00016A0A with FIP_SQRT_ROUND_EN.
- i_rad=0x00000001: o_root=0x00000100. i_rad=0: o_root=0 with o_valid still pulsing.
- i_rad=0xFFFFFFFF: o_root=0x00FFFFFF truncated, 0x01000000 rounded.
- Start 0x00090000, then assert i_en with 0x00010000 at cycle 5 of CALC: ignored, single o_valid with 0x00030000. i_en held high in DONE with 0x00010000: the second op starts and yields 0x00010000 twenty-four cycles later.
- Deassert i_rstn at cycle 10 of CALC: all outputs 0 immediately, no o_valid. After release, a new op (0x00100000) yields 0x00040000.

Source files
------------

// File: rtl/fip_pkg.sv
// ============================================================================
// Module      : fip_pkg
// Description : Shared fixed-point constants and the square-root FSM state type.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fip_pkg;

    localparam int          FIP_FRA_BITS = 16;
    localparam logic [31:0] FIP_MIN      = 32'h0000_0000;
    localparam logic [31:0] FIP_MAX      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fip_sqrt_state_t;

endpackage

`default_nettype wire

// File: rtl/fip_sqrt_step.sv
// ============================================================================
// Module      : fip_sqrt_step
// Description : One combinational restoring digit-by-digit square-root step.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fip_sqrt_step #(
    parameter int ITER = 24
) (
    input  logic [ITER+1:0] i_rem,
    input  logic [ITER-1:0] i_root,
    input  logic [1:0]      i_op2,
    output logic [ITER+1:0] o_rem,
    output logic [ITER-1:0] o_root
);

    logic [ITER+1:0] w_rem_sh;
    logic [ITER+1:0] w_trial;
    logic [ITER+1:0] w_diff;
    logic            w_ge;
    logic            w_unused;

    // Before any step the remainder is below 2^ITER and the root's MSB is clear,
    // so the dropped bits are always zero.
    assign w_unused = ^{i_rem[ITER+1:ITER], i_root[ITER-1]};

    assign w_rem_sh = {i_rem[ITER-1:0], i_op2};
    assign w_trial  = {i_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);
    assign w_diff   = w_rem_sh - w_trial;

    assign o_rem  = w_ge ? w_diff : w_rem_sh;
    assign o_root = {i_root[ITER-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/fip_32_sqrt_iter.sv
// ============================================================================
// Module      : fip_32_sqrt_iter
// Description : Iterative unsigned fixed-point square root, one root bit/clock.
//               FIP_SQRT_ROUND_EN selects round-to-nearest instead of truncation.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fip_32_sqrt_iter
    import fip_pkg::*;
#(
    parameter int FRA_BITS = FIP_FRA_BITS
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic [31:0] i_rad,
    output logic [31:0] o_root,
    output logic        o_busy,
    output logic        o_valid
);

    localparam int ITER = (32 + FRA_BITS) / 2;
    localparam int OPW  = 2 * ITER;
    localparam int RW   = ITER + 1;
    localparam int CNTW = $clog2(ITER + 1);
    localparam logic [CNTW-1:0] C_LAST = CNTW'(ITER - 1);

    fip_sqrt_state_t r_state;
    fip_sqrt_state_t w_next;

    logic [OPW-1:0]  r_op;
    logic [ITER+1:0] r_rem;
    logic [ITER-1:0] r_root;
    logic [CNTW-1:0] r_cnt;
    logic [31:0]     r_out;
    logic            r_busy;
    logic            r_valid;

    logic            w_load;
    logic            w_iter;
    logic            w_last;
    logic [ITER+1:0] w_rem_n;
    logic [ITER-1:0] w_root_n;
    logic [RW-1:0]   w_result;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_en) w_next = CALC;
            CALC:    if (r_cnt == C_LAST) w_next = DONE;
            DONE:    w_next = i_en ? CALC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_iter = 1'b0;
        w_last = 1'b0;
        case (r_state)
            IDLE:    w_load = i_en;
            CALC: begin
                w_iter = 1'b1;
                w_last = (r_cnt == C_LAST);
            end
            DONE:    w_load = i_en;
            default: w_load = 1'b0;
        endcase
    end

    fip_sqrt_step #(
        .ITER (ITER)
    ) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_op2  (r_op[OPW-1:OPW-2]),
        .o_rem  (w_rem_n),
        .o_root (w_root_n)
    );

    // Round up exactly when OP - root^2 > root, i.e. sqrt(OP) >= root + 0.5.
`ifdef FIP_SQRT_ROUND_EN
    assign w_result = {1'b0, w_root_n} + RW'(w_rem_n > {2'b00, w_root_n});
`else
    assign w_result = {1'b0, w_root_n};
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_op    <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_busy  <= (w_next == CALC);
            r_valid <= w_last;
            if (w_load) begin
                r_op   <= OPW'(i_rad) << FRA_BITS;
                r_rem  <= '0;
                r_root <= '0;
                r_cnt  <= '0;
            end else if (w_iter) begin
                r_op   <= r_op << 2;
                r_rem  <= w_rem_n;
                r_root <= w_root_n;
                r_cnt  <= r_cnt + CNTW'(1);
            end
            if (w_last) begin
                r_out <= 32'(w_result);
            end
        end
    end

    assign o_root  = r_out;
    assign o_busy  = r_busy;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_fip_32_sqrt_iter.sv
// ============================================================================
// Module      : tb_fip_32_sqrt_iter
// Description : Scoreboard bench for fip_32_sqrt_iter (honours FIP_SQRT_ROUND_EN).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fip_32_sqrt_iter;

    localparam int FRA  = 16;
    localparam int ITER = (32 + FRA) / 2;

    typedef struct {
        logic [31:0] rad;
        logic [31:0] exp;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_en;
    logic [31:0] i_rad;
    logic [31:0] o_root;
    logic        o_busy;
    logic        o_valid;

    exp_t q[$];
    int   cyc;
    int   tests;
    int   fails;

    fip_32_sqrt_iter #(
        .FRA_BITS (FRA)
    ) dut (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_en    (i_en),
        .i_rad   (i_rad),
        .o_root  (o_root),
        .o_busy  (o_busy),
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Reference: exact square root of rad * 2^FRA, truncated or rounded to nearest.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] rad);
        longint op;
        longint r;
        op = longint'(rad) << FRA;
        r  = longint'($floor($sqrt(real'(op))));
        while (r * r > op) r--;
        while ((r + 1) * (r + 1) <= op) r++;
`ifdef FIP_SQRT_ROUND_EN
        if ((2 * r + 1) * (2 * r + 1) <= 4 * op) r++;
`endif
        return r[31:0];
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Caller positions between edges; the next rising edge is the accept edge.
    task automatic start(input logic [31:0] rad, input logic [31:0] expv);
        exp_t e;
        i_en  = 1'b1;
        i_rad = rad;
        @(posedge clk);
        #1;
        e.rad = rad;
        e.exp = expv;
        e.acc = cyc;
        q.push_back(e);
        i_en = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < ITER + 8; i++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_valid: got no o_valid, expected pulse within %0d cycles", ITER + 8);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * ITER && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending results, expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_valid: got o_valid root=0x%0h, expected none", o_root);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("root(0x%08h)", e.rad), o_root, e.exp);
                check("latency", cyc - e.acc, ITER);
                check("busy_at_valid", o_busy, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        i_en  = 1'b0;
        i_rad = '0;
        repeat (3) @(negedge clk);
        check("reset_root", o_root, 0);
        check("reset_busy", o_busy, 0);
        check("reset_valid", o_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4.0 with busy profile
        start(32'h0004_0000, 32'h0002_0000);
        for (int i = 0; i < ITER; i++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", i), o_busy, 1);
        end
        @(negedge clk);
        check("busy_after", o_busy, 0);
        drain();

`ifdef FIP_SQRT_ROUND_EN
        start(32'h0002_0000, 32'h0001_6A0A);
        drain();
        start(32'hFFFF_FFFF, 32'h0100_0000);
        drain();
`else
        start(32'h0002_0000, 32'h0001_6A09);
        drain();
        start(32'hFFFF_FFFF, 32'h00FF_FFFF);
        drain();
`endif
        start(32'h0000_0001, 32'h0000_0100);
        drain();
        start(32'h0000_0000, 32'h0000_0000);
        drain();

        // i_en during CALC ignored, then restart from DONE
        start(32'h0009_0000, 32'h0003_0000);
        repeat (5) @(negedge clk);
        i_en  = 1'b1;
        i_rad = 32'h0001_0000;
        @(negedge clk);
        i_en  = 1'b0;
        check("root_held_in_calc", o_root, 0);
        wait_valid();
        start(32'h0001_0000, 32'h0001_0000);
        drain();

        // asynchronous reset mid-operation
        start(32'h0009_0000, 32'h0003_0000);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_root", o_root, 0);
        check("arst_busy", o_busy, 0);
        check("arst_valid", o_valid, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (ITER + 4) @(negedge clk);
        start(32'h0010_0000, 32'h0004_0000);
        drain();

        // randomized against the reference model, mixing idle gaps and DONE restarts
        for (int i = 0; i < 40; i++) begin
            r = (i % 3 == 0) ? 32'($urandom_range(0, 65535)) : $urandom;
            start(r, ref_sqrt(r));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                i_en  = 1'b1;
                i_rad = $urandom;
                @(negedge clk);
                i_en  = 1'b0;
            end
            wait_valid();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
